// File: rtl/uart_packet_parser.sv
// Splits a ready/valid byte stream from the UART receiver into packets.
// Each packet is: opcode, reserved, len LSB, len MSB, then (len-4) payload bytes.
// The header goes out on its own channel. Payload bytes pass straight through
// with a last marker. Bad opcodes and bad lengths raise a one-cycle error and
// their bytes are discarded.
module uart_packet_parser #(
  parameter logic [7:0]  OP_ECHO_P = 8'hEC,
  parameter logic [7:0]  OP_ADD_P  = 8'hAD,
  parameter logic [7:0]  OP_MUL_P  = 8'h88,
  parameter logic [7:0]  OP_DIV_P  = 8'hD1,
  parameter logic [15:0] MAX_LEN_P = 16'd260
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        hdr_valid_o,
  input  logic        hdr_ready_i,
  output logic [7:0]  opcode_o,
  output logic [15:0] length_o,
  output logic [7:0]  data_o,
  output logic        data_valid_o,
  output logic        data_last_o,
  input  logic        data_ready_i,
  output logic        error_o
);

  typedef enum logic [2:0] {
    ST_OPCODE,
    ST_RSVD,
    ST_LEN_LSB,
    ST_LEN_MSB,
    ST_HDR,
    ST_PAYLOAD,
    ST_DROP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [15:0] length_q, length_d;
  logic [15:0] remaining_q, remaining_d;
  logic        error_q, error_d;

  logic        rx_xfer;
  logic [15:0] len_full;
  logic        len_short;
  logic        len_bad;
  logic        op_known;

  // The full length is assembled from the MSB byte now on the bus and the
  // LSB byte captured one transfer earlier.
  assign len_full  = {rx_data_i, length_q[7:0]};
  assign len_short = (len_full < 16'd4);
  assign len_bad   = len_short || (len_full > MAX_LEN_P);
  assign op_known  = (opcode_q == OP_ECHO_P) || (opcode_q == OP_ADD_P) ||
                     (opcode_q == OP_MUL_P)  || (opcode_q == OP_DIV_P);

  assign rx_xfer     = rx_valid_i & rx_ready_o;
  assign hdr_valid_o = (state_q == ST_HDR);
  assign opcode_o    = opcode_q;
  assign length_o    = length_q;
  assign error_o     = error_q;
  assign data_o      = rx_data_i;

  // Receiver backpressure: header bytes and dropped bytes are always taken,
  // the header hold stalls the stream, and payload follows the consumer.
  always_comb begin
    rx_ready_o = 1'b0;
    case (state_q)
      ST_OPCODE, ST_RSVD, ST_LEN_LSB, ST_LEN_MSB, ST_DROP: rx_ready_o = 1'b1;
      ST_PAYLOAD: rx_ready_o = data_ready_i;
      default:    rx_ready_o = 1'b0;
    endcase
  end

  // Next-state, field capture, remaining-byte count and payload outputs.
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    length_d     = length_q;
    remaining_d  = remaining_q;
    error_d      = 1'b0;
    data_valid_o = 1'b0;
    data_last_o  = 1'b0;
    case (state_q)
      ST_OPCODE: begin
        if (rx_xfer) begin
          opcode_d = rx_data_i;
          state_d  = ST_RSVD;
        end
      end
      ST_RSVD: begin
        if (rx_xfer) state_d = ST_LEN_LSB;
      end
      ST_LEN_LSB: begin
        if (rx_xfer) begin
          length_d = {length_q[15:8], rx_data_i};
          state_d  = ST_LEN_MSB;
        end
      end
      ST_LEN_MSB: begin
        if (rx_xfer) begin
          length_d    = len_full;
          remaining_d = len_short ? 16'd0 : (len_full - 16'd4);
          if (len_bad) begin
            error_d = 1'b1;
            state_d = len_short ? ST_OPCODE : ST_DROP;
          end else if (!op_known) begin
            error_d = 1'b1;
            state_d = (len_full == 16'd4) ? ST_OPCODE : ST_DROP;
          end else begin
            state_d = ST_HDR;
          end
        end
      end
      ST_HDR: begin
        if (hdr_ready_i) state_d = (remaining_q != 16'd0) ? ST_PAYLOAD : ST_OPCODE;
      end
      ST_PAYLOAD: begin
        data_valid_o = rx_valid_i;
        data_last_o  = rx_valid_i && (remaining_q == 16'd1);
        if (rx_xfer) begin
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) state_d = ST_OPCODE;
        end
      end
      ST_DROP: begin
        if (rx_xfer) begin
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) state_d = ST_OPCODE;
        end
      end
      default: state_d = ST_OPCODE;
    endcase
  end

  // State and field registers; reset abandons any partial packet.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_OPCODE;
      opcode_q    <= 8'd0;
      length_q    <= 16'd0;
      remaining_q <= 16'd0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      length_q    <= length_d;
      remaining_q <= remaining_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: tb/tb_uart_packet_parser.sv
// Bench for uart_packet_parser: directed packets plus randomized packet
// streams with random gaps and backpressure, checked against a packet-level
// reference model that turns a byte stream into an ordered list of events.
module tb_uart_packet_parser;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_MUL  = 8'h88;
  localparam logic [7:0] OP_DIV  = 8'hD1;
  localparam int         MAX_LEN = 260;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        hdr_valid_o;
  logic        hdr_ready_i;
  logic [7:0]  opcode_o;
  logic [15:0] length_o;
  logic [7:0]  data_o;
  logic        data_valid_o;
  logic        data_last_o;
  logic        data_ready_i;
  logic        error_o;

  uart_packet_parser dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .rx_data_i    (rx_data_i),
    .rx_valid_i   (rx_valid_i),
    .rx_ready_o   (rx_ready_o),
    .hdr_valid_o  (hdr_valid_o),
    .hdr_ready_i  (hdr_ready_i),
    .opcode_o     (opcode_o),
    .length_o     (length_o),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .data_last_o  (data_last_o),
    .data_ready_i (data_ready_i),
    .error_o      (error_o)
  );

  // Free-running clock, 10 ns period.
  always #5 clk_i = ~clk_i;

  logic [7:0]  txQ[$];
  logic [31:0] expQ[$];
  int          checks = 0;
  int          failures = 0;
  bit          randReady = 1'b0;
  bit          useGaps = 1'b0;
  int          hdrLowCycles = 0;
  bit          prevErr = 1'b0;

  // Single comparison point: every check is counted here and reported on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Event encodings: top byte is the kind, the rest carries the fields.
  function automatic logic [31:0] hdrEvt(input logic [7:0] op, input logic [15:0] len);
    return {8'd1, op, len};
  endfunction

  function automatic logic [31:0] dataEvt(input logic [7:0] b, input bit last);
    return {8'd2, 7'd0, last, 8'd0, b};
  endfunction

  function automatic logic [31:0] errEvt();
    return {8'd3, 24'd0};
  endfunction

  // Reference model: walk the byte stream packet by packet using the length
  // field and emit the events a correct parser must produce, in order.
  function automatic void buildExpected();
    int n = txQ.size();
    int i = 0;
    while (i + 4 <= n) begin
      logic [7:0] op = txQ[i];
      int len = int'(txQ[i+2]) + 256 * int'(txQ[i+3]);
      bit known = (op == OP_ECHO) || (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
      if (len < 4) begin
        expQ.push_back(errEvt());
        i += 4;
      end else if (len > MAX_LEN || !known) begin
        expQ.push_back(errEvt());
        i += len;
      end else begin
        expQ.push_back(hdrEvt(op, 16'(len)));
        for (int k = 0; k < len - 4; k++)
          expQ.push_back(dataEvt(txQ[i+4+k], k == len - 5));
        i += len;
      end
    end
  endfunction

  // Append one packet with a random reserved byte and random payload.
  task automatic addPacket(input logic [7:0] op, input int len);
    txQ.push_back(op);
    txQ.push_back(8'($urandom));
    txQ.push_back(8'(len));
    txQ.push_back(8'(len >> 8));
    for (int k = 0; k < len - 4; k++) txQ.push_back(8'($urandom));
  endtask

  // Feed txQ into the parser one byte per handshake, with optional idle gaps.
  task automatic applyStimulus(input string tag);
    int budget = 0;
    bit took;
    while (txQ.size() > 0 && budget < 20000) begin
      rx_data_i  = txQ[0];
      rx_valid_i = !(useGaps && ($urandom_range(0, 3) == 0));
      @(negedge clk_i);
      took = rx_valid_i && rx_ready_o;
      @(posedge clk_i);
      #1;
      if (took) void'(txQ.pop_front());
      budget++;
    end
    rx_valid_i = 1'b0;
    checkOutput({tag, "_bytes_left"}, 32'(txQ.size()), 32'd0);
    txQ.delete();
  endtask

  // Wait a bounded time for all expected events, then confirm nothing is left.
  task automatic waitDrain(input string tag);
    for (int c = 0; c < 300 && expQ.size() != 0; c++) begin
      @(posedge clk_i);
      #1;
    end
    repeat (3) begin
      @(posedge clk_i);
      #1;
    end
    checkOutput({tag, "_events_left"}, 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  // Compare one observed event against the head of the expected list.
  task automatic observeEvent(input string tag, input logic [31:0] val);
    if (expQ.size() == 0) checkOutput({tag, "_unexpected"}, val, 32'hFFFF_FFFF);
    else checkOutput(tag, val, expQ.pop_front());
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_opcode"}, 32'(opcode_o), 32'd0);
    checkOutput({tag, "_length"}, 32'(length_o), 32'd0);
    checkOutput({tag, "_hdr_valid"}, 32'(hdr_valid_o), 32'd0);
    checkOutput({tag, "_error"}, 32'(error_o), 32'd0);
    checkOutput({tag, "_data_valid"}, 32'(data_valid_o), 32'd0);
    checkOutput({tag, "_data_last"}, 32'(data_last_o), 32'd0);
    checkOutput({tag, "_rx_ready"}, 32'(rx_ready_o), 32'd1);
  endtask

  // Consumer side: ready signals change just after each rising edge; the
  // header can be forced low for a number of header-valid cycles.
  always @(posedge clk_i) begin
    #1;
    data_ready_i = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    if (hdrLowCycles > 0) begin
      hdr_ready_i = 1'b0;
      if (hdr_valid_o) hdrLowCycles--;
    end else begin
      hdr_ready_i = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor on the falling edge: record handshakes and errors, check stalls.
  always @(negedge clk_i) begin
    if (reset_i === 1'b0) begin
      if (error_o) begin
        if (prevErr) checkOutput("err_back_to_back", 32'd1, 32'd0);
        observeEvent("err_evt", errEvt());
      end
      prevErr = error_o;
      if (hdr_valid_o && hdr_ready_i) observeEvent("hdr_evt", hdrEvt(opcode_o, length_o));
      if (data_valid_o && data_ready_i) observeEvent("data_evt", dataEvt(data_o, data_last_o));
      if (hdr_valid_o) checkOutput("hdr_stalls_rx", 32'(rx_ready_o), 32'd0);
      if (data_valid_o) checkOutput("payload_rx_ready", 32'(rx_ready_o), 32'(data_ready_i));
    end else begin
      prevErr = 1'b0;
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence: reset, directed packets, reset mid-packet, random streams.
  initial begin
    reset_i      = 1'b1;
    rx_valid_i   = 1'b0;
    rx_data_i    = 8'h00;
    hdr_ready_i  = 1'b1;
    data_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    checkResetState("reset");
    rx_valid_i = 1'b0;
    reset_i    = 1'b0;

    $display("[TB] echo packet with 8 payload bytes");
    txQ = '{8'hEC, 8'h00, 8'h0C, 8'h00, 8'h48, 8'h69, 8'h01, 8'h02,
            8'h03, 8'h04, 8'h05, 8'h06};
    buildExpected();
    applyStimulus("echo8");
    waitDrain("echo8");

    $display("[TB] header-only add packet then one-byte echo");
    txQ = '{8'hAD, 8'h00, 8'h04, 8'h00, 8'hEC, 8'h00, 8'h05, 8'h00, 8'h7F};
    buildExpected();
    applyStimulus("hdr_only");
    waitDrain("hdr_only");

    $display("[TB] unknown opcode dropped then echo");
    txQ = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB, 8'hEC, 8'h00, 8'h05, 8'h00, 8'h11};
    buildExpected();
    applyStimulus("bad_op");
    waitDrain("bad_op");

    $display("[TB] short length and oversize length");
    txQ = '{8'hEC, 8'h00, 8'h02, 8'h00, 8'hEC, 8'h00, 8'h05, 8'h01};
    for (int k = 0; k < 257; k++) txQ.push_back(8'($urandom));
    addPacket(OP_ECHO, 5);
    buildExpected();
    useGaps = 1'b1;
    applyStimulus("bad_len");
    waitDrain("bad_len");

    $display("[TB] echo packet under backpressure");
    addPacket(OP_ECHO, 24);
    buildExpected();
    randReady    = 1'b1;
    hdrLowCycles = 10;
    applyStimulus("stall");
    waitDrain("stall");
    checkOutput("stall_hdr_hold_done", 32'(hdrLowCycles), 32'd0);

    $display("[TB] reset after third payload byte");
    randReady = 1'b0;
    useGaps   = 1'b0;
    addPacket(OP_ECHO, 10);
    buildExpected();
    while (expQ.size() > 4) void'(expQ.pop_back());
    while (txQ.size() > 7) void'(txQ.pop_back());
    applyStimulus("pre_reset");
    checkOutput("pre_reset_events_left", 32'(expQ.size()), 32'd0);
    reset_i    = 1'b1;
    rx_valid_i = 1'b1;
    rx_data_i  = 8'hEC;
    @(posedge clk_i);
    #1;
    checkResetState("mid_reset");
    rx_valid_i = 1'b0;
    reset_i    = 1'b0;
    txQ = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h01, 8'h02};
    buildExpected();
    applyStimulus("post_reset");
    waitDrain("post_reset");

    $display("[TB] random packet stream");
    randReady = 1'b1;
    useGaps   = 1'b1;
    for (int p = 0; p < 40; p++) begin
      logic [7:0] op;
      int         len;
      int         pick = $urandom_range(0, 9);
      case ($urandom_range(0, 4))
        0: op = OP_ECHO;
        1: op = OP_ADD;
        2: op = OP_MUL;
        3: op = OP_DIV;
        default: op = 8'($urandom);
      endcase
      if (pick == 0) len = $urandom_range(0, 3);
      else if (pick == 1) len = $urandom_range(258, 266);
      else len = $urandom_range(4, 16);
      addPacket(op, len);
    end
    buildExpected();
    applyStimulus("random");
    waitDrain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
